imm_field_encoder: RTL and testbench

//  Packs decoded instruction fields into 32-bit SCU instruction words, the inverse of immGenMux2's sign extension.

---
 rtl/imm_field_encoder_if.sv | 37 +++
 rtl/imm_field_encoder.sv | 153 +++++++++++++++
 tb/tb_imm_field_encoder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_field_encoder_if.sv
// ---------------------------------------------------------------------------
// imm_field_encoder_if
//   Handshake bundle between the loader front end, the field encoder and
//   instruction memory.
//   Input side : in_valid/in_ready handshake with the decoded fields
//                (in_fmt, in_op, in_rd, in_rs, in_imm).
//   Output side: out_valid/out_ready handshake with the packed word,
//                its write address and the range-error flag.
//   Modports   : slave  - the encoder's view
//                master - the surrounding logic's view (loader + memory)
// ---------------------------------------------------------------------------
interface imm_field_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_fmt;
  logic [3:0]        in_op;
  logic [5:0]        in_rd;
  logic [5:0]        in_rs;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport slave (
    input  in_valid, in_fmt, in_op, in_rd, in_rs, in_imm, out_ready,
    output in_ready, out_valid, out_word, out_addr, out_err
  );

  modport master (
    output in_valid, in_fmt, in_op, in_rd, in_rs, in_imm, out_ready,
    input  in_ready, out_valid, out_word, out_addr, out_err
  );
endinterface

// File: rtl/imm_field_encoder.sv
// ---------------------------------------------------------------------------
// imm_field_encoder
//   Packs decoded instruction fields into 32-bit SCU instruction words
//   (the inverse of the immediate sign extension in the decoder), narrows
//   and range-checks the immediate, and streams the words through a
//   2-entry output buffer together with the instruction-memory address.
//
//   Word layout:  I-format {op[3:0], rd[5:0], rs[5:0], imm[15:0]}
//                 J-format {op[3:0], rd[5:0], imm[21:0]}
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   addr_clr   synchronous clear of the write address (wins over increment)
//   bus        imm_field_encoder_if.slave: input fields + output word stream
//   err_count  saturating count of accepted out-of-range immediates
//
// Configuration
//   IMM_SAT_EN  when defined, an out-of-range immediate saturates to the
//               field limit selected by the sign bit instead of being
//               truncated. The error flag/counter behave the same either way.
// ---------------------------------------------------------------------------
module imm_field_encoder #(
  parameter int ADDR_W   = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                addr_clr,
  imm_field_encoder_if.slave  bus,
  output logic [ERRCNT_W-1:0] err_count
);

  // Buffer occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  buf_state_t          state_reg, state_next;
  logic [31:0]         word_mem [2];
  logic                err_mem  [2];
  logic                wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ERRCNT_W-1:0] err_count_reg;

  logic                push, pop;
  logic                fits_i, fits_j, in_err;
  logic [15:0]         imm16;
  logic [21:0]         imm22;
  logic [31:0]         packed_word;

  // ---------------------------------------------------------------------
  // Field narrowing and range check
  // ---------------------------------------------------------------------
  // A value fits an N-bit signed field when bits [31:N-1] are all copies
  // of the field's sign bit.
  assign fits_i = (&bus.in_imm[31:15]) | ~(|bus.in_imm[31:15]);
  assign fits_j = (&bus.in_imm[31:21]) | ~(|bus.in_imm[31:21]);
  assign in_err = bus.in_fmt ? ~fits_j : ~fits_i;

  always_comb begin
    imm16 = bus.in_imm[15:0];
    imm22 = bus.in_imm[21:0];
`ifdef IMM_SAT_EN
    if (!fits_i) imm16 = bus.in_imm[31] ? 16'h8000 : 16'h7FFF;
    if (!fits_j) imm22 = bus.in_imm[31] ? 22'h200000 : 22'h1FFFFF;
`endif
    if (bus.in_fmt) packed_word = {bus.in_op, bus.in_rd, imm22};
    else            packed_word = {bus.in_op, bus.in_rd, bus.in_rs, imm16};
  end

  // ---------------------------------------------------------------------
  // Handshakes. in_ready depends only on registered state, so there is no
  // combinational path from out_ready back to in_ready.
  // ---------------------------------------------------------------------
  assign bus.in_ready  = (state_reg != FULL);
  assign bus.out_valid = (state_reg != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // ---------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      // in_ready is low when full, so only a pop can happen here.
      FULL:  if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_mem[0] <= '0;
      word_mem[1] <= '0;
      err_mem[0]  <= 1'b0;
      err_mem[1]  <= 1'b0;
      wr_ptr_reg  <= 1'b0;
    end else if (push) begin
      word_mem[wr_ptr_reg] <= packed_word;
      err_mem[wr_ptr_reg]  <= in_err;
      wr_ptr_reg           <= ~wr_ptr_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_ptr_reg <= 1'b0;
    else if (pop) rd_ptr_reg <= ~rd_ptr_reg;
  end

  // ---------------------------------------------------------------------
  // Write address: tracks the head entry; clear takes priority.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        addr_reg <= '0;
    else if (addr_clr) addr_reg <= '0;
    else if (pop)      addr_reg <= addr_reg + ADDR_W'(1);
  end

  // ---------------------------------------------------------------------
  // Saturating error counter, counted at acceptance time.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count_reg <= '0;
    else if (push && in_err && (err_count_reg != {ERRCNT_W{1'b1}}))
      err_count_reg <= err_count_reg + ERRCNT_W'(1);
  end

  // Head entry is masked to zero while the buffer is empty so an idle
  // output never shows stale data.
  assign bus.out_word = bus.out_valid ? word_mem[rd_ptr_reg] : 32'h0;
  assign bus.out_err  = bus.out_valid & err_mem[rd_ptr_reg];
  assign bus.out_addr = addr_reg;
  assign err_count    = err_count_reg;

endmodule

// File: tb/tb_imm_field_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_field_encoder
//   Directed bench for imm_field_encoder: a table of single-word vectors
//   with hand-computed words, then hand-written sequences for back-pressure,
//   address wrap/clear and reset with a full buffer.
// ---------------------------------------------------------------------------
module tb_imm_field_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       addr_clr;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  imm_field_encoder_if #(.ADDR_W(8)) dif ();

  imm_field_encoder #(.ADDR_W(8), .ERRCNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_clr  (addr_clr),
    .bus       (dif.slave),
    .err_count (err_count)
  );

  typedef struct {
    logic        fmt;
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [5:0]  rs;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fmt, input logic [3:0] op, input logic [5:0] rd,
                       input logic [5:0] rs, input logic [31:0] imm);
    dif.in_fmt = fmt;
    dif.in_op  = op;
    dif.in_rd  = rd;
    dif.in_rs  = rs;
    dif.in_imm = imm;
  endtask

  logic [7:0]  exp_addr;
  logic [7:0]  exp_errs;
  logic [31:0] drain_exp [3];
  int          got;
  int          hs;
  logic        acc_c;

  initial begin
    // fmt, op, rd, rs, imm, expected word, expected err
    vecs[0] = '{1'b0, 4'h5, 6'd3,  6'd7,  32'hFFFF_FFFE, 32'h50C7_FFFE, 1'b0};
    vecs[1] = '{1'b1, 4'hA, 6'd1,  6'h3F, 32'hFFE0_0000, 32'hA060_0000, 1'b0};
`ifdef IMM_SAT_EN
    vecs[2] = '{1'b0, 4'h1, 6'd2,  6'd4,  32'h0000_8000, 32'h1084_7FFF, 1'b1};
    vecs[5] = '{1'b0, 4'h0, 6'd0,  6'd1,  32'hFFFF_7FFF, 32'h0001_8000, 1'b1};
    vecs[7] = '{1'b1, 4'h2, 6'd5,  6'd0,  32'h0020_0000, 32'h215F_FFFF, 1'b1};
    vecs[8] = '{1'b1, 4'h3, 6'd0,  6'd0,  32'h8000_0000, 32'h3020_0000, 1'b1};
`else
    vecs[2] = '{1'b0, 4'h1, 6'd2,  6'd4,  32'h0000_8000, 32'h1084_8000, 1'b1};
    vecs[5] = '{1'b0, 4'h0, 6'd0,  6'd1,  32'hFFFF_7FFF, 32'h0001_7FFF, 1'b1};
    vecs[7] = '{1'b1, 4'h2, 6'd5,  6'd0,  32'h0020_0000, 32'h2160_0000, 1'b1};
    vecs[8] = '{1'b1, 4'h3, 6'd0,  6'd0,  32'h8000_0000, 32'h3000_0000, 1'b1};
`endif
    vecs[3] = '{1'b0, 4'hF, 6'h3F, 6'h3F, 32'h0000_7FFF, 32'hFFFF_7FFF, 1'b0};
    vecs[4] = '{1'b0, 4'h0, 6'd0,  6'd0,  32'hFFFF_8000, 32'h0000_8000, 1'b0};
    vecs[6] = '{1'b1, 4'h2, 6'd5,  6'd0,  32'h001F_FFFF, 32'h215F_FFFF, 1'b0};

    rst_n         = 1'b0;
    addr_clr      = 1'b0;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    drive(1'b0, 4'h0, 6'd0, 6'd0, 32'h0);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, dif.out_valid}, 32'd0);
    chk("rst_out_word",  dif.out_word, 32'd0);
    chk("rst_out_err",   {31'b0, dif.out_err}, 32'd0);
    chk("rst_out_addr",  {24'b0, dif.out_addr}, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, dif.in_ready}, 32'd1);

    // ---- table vectors: one word at a time, out_ready held high ----
    exp_addr = 8'd0;
    exp_errs = 8'd0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm);
      dif.in_valid  = 1'b1;
      dif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
      if (vecs[i].err) exp_errs = exp_errs + 8'd1;
      $display("vec %0d: fmt=%0d imm=0x%08h word=0x%08h err=%0d addr=%0d errcnt=%0d",
               i, vecs[i].fmt, vecs[i].imm, dif.out_word, dif.out_err, dif.out_addr, err_count);
      chk($sformatf("vec%0d_valid", i), {31'b0, dif.out_valid}, 32'd1);
      chk($sformatf("vec%0d_word", i),  dif.out_word, vecs[i].word);
      chk($sformatf("vec%0d_err", i),   {31'b0, dif.out_err}, {31'b0, vecs[i].err});
      chk($sformatf("vec%0d_addr", i),  {24'b0, dif.out_addr}, {24'b0, exp_addr});
      chk($sformatf("vec%0d_errcnt", i), {24'b0, err_count}, {24'b0, exp_errs});
      @(posedge clk);
      #1;
      exp_addr = exp_addr + 8'd1;
    end
    chk("vec_drained", {31'b0, dif.out_valid}, 32'd0);

    // ---- back-pressure: three pushes with out_ready low ----
    drain_exp[0] = 32'h1041_0001;
    drain_exp[1] = 32'h1041_0002;
    drain_exp[2] = 32'h1041_0003;
    @(negedge clk);
    dif.out_ready = 1'b0;
    drive(1'b0, 4'h1, 6'd1, 6'd1, 32'd1);
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 4'h1, 6'd1, 6'd1, 32'd2);
    @(posedge clk);
    #1;
    chk("bp_in_ready_full", {31'b0, dif.in_ready}, 32'd0);
    chk("bp_head_word", dif.out_word, drain_exp[0]);
    drive(1'b0, 4'h1, 6'd1, 6'd1, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    $display("bp hold: in_ready=%0d out_valid=%0d word=0x%08h", dif.in_ready, dif.out_valid, dif.out_word);
    chk("bp_hold_ready", {31'b0, dif.in_ready}, 32'd0);
    chk("bp_hold_valid", {31'b0, dif.out_valid}, 32'd1);
    chk("bp_hold_word", dif.out_word, drain_exp[0]);
    chk("bp_hold_addr", {24'b0, dif.out_addr}, {24'b0, exp_addr});

    @(negedge clk);
    dif.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (c != 0) @(negedge clk);
      if (dif.out_valid && dif.out_ready) begin
        $display("bp drain %0d: word=0x%08h addr=%0d", got, dif.out_word, dif.out_addr);
        chk($sformatf("bp_drain%0d_word", got), dif.out_word, drain_exp[got]);
        chk($sformatf("bp_drain%0d_addr", got), {24'b0, dif.out_addr}, {24'b0, exp_addr});
        exp_addr = exp_addr + 8'd1;
        got++;
      end
      acc_c = dif.in_valid && dif.in_ready;
      @(posedge clk);
      #1;
      if (acc_c) dif.in_valid = 1'b0;
    end
    chk("bp_drain_count", got, 32'd3);
    chk("bp_empty_after", {31'b0, dif.out_valid}, 32'd0);
    dif.in_valid = 1'b0;

    // ---- address clear, wrap, and clear beating an increment ----
    @(negedge clk);
    addr_clr = 1'b1;
    @(posedge clk);
    #1;
    addr_clr = 1'b0;
    chk("clr_addr_idle", {24'b0, dif.out_addr}, 32'd0);
    @(negedge clk);
    drive(1'b0, 4'h0, 6'd0, 6'd0, 32'd0);
    dif.in_valid  = 1'b1;
    dif.out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (dif.out_addr == 8'hFF) break;
      if (dif.out_valid && dif.out_ready) hs++;
    end
    $display("wrap: reached addr=0x%02h after %0d handshakes", dif.out_addr, hs);
    chk("wrap_reach_ff", {24'b0, dif.out_addr}, 32'hFF);
    chk("wrap_hs_count", hs, 32'd255);
    chk("wrap_valid_at_ff", {31'b0, dif.out_valid}, 32'd1);
    @(negedge clk);
    chk("wrap_to_zero", {24'b0, dif.out_addr}, 32'd0);
    chk("wrap_valid_after", {31'b0, dif.out_valid}, 32'd1);
    dif.in_valid = 1'b0;
    addr_clr     = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0;
    $display("clr+handshake: addr=%0d out_valid=%0d", dif.out_addr, dif.out_valid);
    chk("clr_over_inc", {24'b0, dif.out_addr}, 32'd0);
    chk("clr_pop_empty", {31'b0, dif.out_valid}, 32'd0);
    chk("errcnt_unchanged", {24'b0, err_count}, {24'b0, exp_errs});

    // ---- reset with the buffer full ----
    dif.out_ready = 1'b0;
    drive(1'b0, 4'h2, 6'd2, 6'd2, 32'h0001_0000);
    dif.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("full_in_ready", {31'b0, dif.in_ready}, 32'd0);
    chk("full_errcnt", {24'b0, err_count}, {24'b0, exp_errs + 8'd2});
    @(negedge clk);
    rst_n        = 1'b0;
    dif.in_valid = 1'b0;
    #1;
    $display("mid reset: out_valid=%0d errcnt=%0d addr=%0d", dif.out_valid, err_count, dif.out_addr);
    chk("mrst_out_valid", {31'b0, dif.out_valid}, 32'd0);
    chk("mrst_errcnt", {24'b0, err_count}, 32'd0);
    chk("mrst_word", dif.out_word, 32'd0);
    chk("mrst_err", {31'b0, dif.out_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready", {31'b0, dif.in_ready}, 32'd1);
    chk("mrst_addr", {24'b0, dif.out_addr}, 32'd0);

    // One word after reset to confirm the buffer starts clean.
    @(negedge clk);
    drive(vecs[0].fmt, vecs[0].op, vecs[0].rd, vecs[0].rs, vecs[0].imm);
    dif.in_valid  = 1'b1;
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    $display("post reset: word=0x%08h addr=%0d", dif.out_word, dif.out_addr);
    chk("post_word", dif.out_word, vecs[0].word);
    chk("post_addr", {24'b0, dif.out_addr}, 32'd0);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
